// File: rtl/ft_bus_arbiter.sv
// Half-duplex scheduler for a 32-bit FT245/FT600-style synchronous FIFO bus.
// Picks RX or TX each burst and drives the bus strobes and FIFO handshakes.
module ft_bus_arbiter #(
  parameter int MAX_BURST   = 256,
  parameter int TURN_CYCLES = 1,
  parameter int CNT_W       = 9
) (
  input  logic usb_clk,
  input  logic rst,
  input  logic usb_rxf,
  input  logic usb_txe,
  input  logic tx_req,
  input  logic rx_ready,
  output logic usb_oe,
  output logic usb_rd,
  output logic usb_wr,
  output logic drive_en,
  output logic rx_capture,
  output logic tx_advance,
  output logic busy,
  output logic dir
);

  typedef enum logic [2:0] {
    IDLE,
    RD_OE,
    RD_BURST,
    WR_BURST,
    TURN
  } state_t;

  localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [TURN_W-1:0] LAST_TURN = TURN_W'(TURN_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic                dir_q, dir_d;
  logic                rd_want, wr_want;

  assign rd_want = usb_rxf & rx_ready;
  assign wr_want = usb_txe & tx_req;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge usb_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      turn_q  <= '0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      turn_q  <= turn_d;
      dir_q   <= dir_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    turn_d     = turn_q;
    dir_d      = dir_q;
    usb_oe     = 1'b0;
    usb_rd     = 1'b0;
    usb_wr     = 1'b0;
    drive_en   = 1'b0;
    rx_capture = 1'b0;
    tx_advance = 1'b0;

    case (state_q)
      IDLE: begin
        // On contention the direction not used last time wins; dir resets
        // to write so the first contended grant is a read.
        if (rd_want && (!wr_want || dir_q)) begin
          state_d = RD_OE;
          dir_d   = 1'b0;
          cnt_d   = '0;
        end else if (wr_want) begin
          state_d = WR_BURST;
          dir_d   = 1'b1;
          cnt_d   = '0;
        end
      end

      RD_OE: begin
        usb_oe  = 1'b1;
        state_d = RD_BURST;
      end

      RD_BURST: begin
        usb_oe     = 1'b1;
        usb_rd     = rx_ready && (cnt_q < MAX_CNT);
        rx_capture = usb_rd && usb_rxf;
        if (rx_capture) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!usb_rxf || !rx_ready || (rx_capture && (cnt_q == LAST_BEAT))) begin
          state_d = TURN;
          turn_d  = '0;
        end
      end

      WR_BURST: begin
        drive_en   = 1'b1;
        usb_wr     = tx_req && usb_txe && (cnt_q < MAX_CNT);
        tx_advance = usb_wr;
        if (usb_wr) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!tx_req || !usb_txe || (usb_wr && (cnt_q == LAST_BEAT))) begin
          state_d = TURN;
          turn_d  = '0;
        end
      end

      TURN: begin
        if (turn_q == LAST_TURN) begin
          state_d = IDLE;
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign dir  = dir_q;

endmodule
